// File: rtl/sao_stat_cate_accum_if.sv
// Bus interface for the SAO per-category statistics accumulator.
// Input side: beat handshake (in_valid/in_ready), in_last, and per-pixel use/category/diff.
// Output side: result handshake (out_valid/out_ready), out_idx, out_sum, out_cnt, out_last.
// Modports:
//   master : beat producer and result consumer.
//   slave  : the accumulator.
interface sao_stat_cate_accum_if #(
  parameter int unsigned N_PIX  = 4,
  parameter int unsigned DIFF_W = 5,
  parameter int unsigned CATE_W = 5,
  parameter int unsigned ACC_W  = 18,
  parameter int unsigned CNT_W  = 12
);
  logic                             in_valid;
  logic                             in_ready;
  logic                             in_last;
  logic [N_PIX-1:0]                 in_use;
  logic [N_PIX-1:0][CATE_W-1:0]     in_cate;
  logic [N_PIX-1:0][DIFF_W-1:0]     in_diff;
  logic                             out_valid;
  logic                             out_ready;
  logic [CATE_W-1:0]                out_idx;
  logic signed [ACC_W-1:0]          out_sum;
  logic [CNT_W-1:0]                 out_cnt;
  logic                             out_last;

  modport master (
    output in_valid, in_last, in_use, in_cate, in_diff, out_ready,
    input  in_ready, out_valid, out_idx, out_sum, out_cnt, out_last
  );

  modport slave (
    input  in_valid, in_last, in_use, in_cate, in_diff, out_ready,
    output in_ready, out_valid, out_idx, out_sum, out_cnt, out_last
  );
endinterface

// File: rtl/sao_stat_cate_accum.sv
// SAO per-category statistics accumulator.
// Collects N_PIX pixels per beat over one CTB into per-category saturating diff sums and
// pixel counts, then streams the N_CATE results out over a valid/ready handshake.
// Ports:
//   clk, arst_n (async active-low reset), rst_n (sync active-low clear)
//   ctb_start : clears the accumulators and starts a CTB (honoured only when idle)
//   busy      : state is not IDLE
//   bus       : sao_stat_cate_accum_if.slave (beat input and result output)
// Optional build macro SAO_STAT_SKIP_EMPTY_EN: the readout skips categories with zero count.
module sao_stat_cate_accum #(
  parameter int unsigned N_PIX  = 4,
  parameter int unsigned DIFF_W = 5,
  parameter int unsigned N_CATE = 32,
  parameter int unsigned CATE_W = 5,
  parameter int unsigned ACC_W  = 18,
  parameter int unsigned CNT_W  = 12
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   rst_n,
  input  logic                   ctb_start,
  output logic                   busy,
  sao_stat_cate_accum_if.slave   bus
);

  localparam int unsigned BW  = DIFF_W + $clog2(N_PIX);
  localparam int unsigned PCW = $clog2(N_PIX + 1);
  localparam int unsigned EW  = ACC_W + 1;
  localparam int unsigned CW  = CNT_W + PCW;

  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, READ} state_e;

  state_e                   state_q, state_d;
  logic                     flush_q, flush_d;
  logic [CATE_W-1:0]        rd_idx_q, rd_idx_d;

  logic                     s1_valid_q, s1_valid_d;
  logic [N_PIX-1:0]         s1_inc_q, s1_inc_d;
  logic [CATE_W-1:0]        s1_cate_q [N_PIX];
  logic [CATE_W-1:0]        s1_cate_d [N_PIX];
  logic signed [DIFF_W-1:0] s1_diff_q [N_PIX];
  logic signed [DIFF_W-1:0] s1_diff_d [N_PIX];

  logic signed [ACC_W-1:0]  sum_q [N_CATE];
  logic signed [ACC_W-1:0]  sum_d [N_CATE];
  logic [CNT_W-1:0]         cnt_q [N_CATE];
  logic [CNT_W-1:0]         cnt_d [N_CATE];

  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;
  logic                     out_valid_q, out_valid_d;
  logic [CATE_W-1:0]        out_idx_q, out_idx_d;
  logic signed [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;
  logic                     out_last_q, out_last_d;

  logic signed [BW-1:0]     beat_sum_c [N_CATE];
  logic [PCW-1:0]           beat_cnt_c [N_CATE];
  logic signed [ACC_W-1:0]  acc_sum_c [N_CATE];
  logic [CNT_W-1:0]         acc_cnt_c [N_CATE];
  logic [CATE_W-1:0]        sel_idx_c;
  logic signed [ACC_W-1:0]  rd_sum_c;
  logic [CNT_W-1:0]         rd_cnt_c;
  logic                     accept_c;

  assign accept_c      = bus.in_valid && in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;

  // Per-category contribution of the registered beat; duplicates fold into one entry.
  always_comb begin
    for (int unsigned c = 0; c < N_CATE; c++) begin
      beat_sum_c[c] = '0;
      beat_cnt_c[c] = '0;
      for (int unsigned i = 0; i < N_PIX; i++) begin
        if (s1_inc_q[i] && (s1_cate_q[i] == CATE_W'(c))) begin
          beat_sum_c[c] = beat_sum_c[c] + BW'(s1_diff_q[i]);
          beat_cnt_c[c] = beat_cnt_c[c] + PCW'(1);
        end
      end
    end
  end

  // Saturating accumulate: one guard bit detects sum overflow, PCW extra bits for count.
  always_comb begin
    logic signed [EW-1:0] sx;
    logic [CW-1:0]        cx;
    for (int unsigned c = 0; c < N_CATE; c++) begin
      sx = EW'(sum_q[c]) + EW'(beat_sum_c[c]);
      if (sx[EW-1] != sx[EW-2]) acc_sum_c[c] = sx[EW-1] ? SUM_MIN : SUM_MAX;
      else                      acc_sum_c[c] = sx[ACC_W-1:0];
      cx = CW'(cnt_q[c]) + CW'(beat_cnt_c[c]);
      acc_cnt_c[c] = (cx > CW'(CNT_MAX)) ? CNT_MAX : CNT_W'(cx);
    end
  end

  // Readout mux: the category whose entry is loaded into the output registers next.
  always_comb begin
`ifdef SAO_STAT_SKIP_EMPTY_EN
    sel_idx_c = rd_idx_q;
`else
    sel_idx_c = (state_q == FLUSH) ? '0 : rd_idx_q + CATE_W'(1);
`endif
    rd_sum_c = '0;
    rd_cnt_c = '0;
    for (int unsigned c = 0; c < N_CATE; c++) begin
      if (sel_idx_c == CATE_W'(c)) begin
        rd_sum_c = sum_q[c];
        rd_cnt_c = cnt_q[c];
      end
    end
  end

`ifdef SAO_STAT_SKIP_EMPTY_EN
  // Any non-empty category after rd_idx: decides out_last for the presented entry.
  logic any_later_c;
  always_comb begin
    any_later_c = 1'b0;
    for (int unsigned c = 0; c < N_CATE; c++) begin
      if ((32'(rd_idx_q) < c) && (cnt_q[c] != '0)) any_later_c = 1'b1;
    end
  end
`endif

  // Next-state and datapath updates.
  always_comb begin
    logic inc;
    inc         = 1'b0;
    state_d     = state_q;
    flush_d     = flush_q;
    rd_idx_d    = rd_idx_q;
    s1_valid_d  = 1'b0;
    s1_inc_d    = s1_inc_q;
    s1_cate_d   = s1_cate_q;
    s1_diff_d   = s1_diff_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;

    if (s1_valid_q) begin
      sum_d = acc_sum_c;
      cnt_d = acc_cnt_c;
    end

    unique case (state_q)
      IDLE: begin
        if (ctb_start) begin
          for (int unsigned c = 0; c < N_CATE; c++) begin
            sum_d[c] = '0;
            cnt_d[c] = '0;
          end
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          s1_valid_d = 1'b1;
          for (int unsigned i = 0; i < N_PIX; i++) begin
            inc          = bus.in_use[i] && (32'(bus.in_cate[i]) < N_CATE);
            s1_inc_d[i]  = inc;
            s1_cate_d[i] = bus.in_cate[i];
            s1_diff_d[i] = inc ? $signed(bus.in_diff[i]) : '0;
          end
          if (bus.in_last) begin
            state_d = FLUSH;
            flush_d = 1'b0;
          end
        end
      end
      // Two cycles: S1 register, then the S2 write of the final beat.
      FLUSH: begin
        if (flush_q) begin
          state_d  = READ;
          rd_idx_d = '0;
`ifndef SAO_STAT_SKIP_EMPTY_EN
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          out_sum_d   = rd_sum_c;
          out_cnt_d   = rd_cnt_c;
          out_last_d  = (N_CATE == 1);
`endif
        end else begin
          flush_d = 1'b1;
        end
      end
      READ: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          state_d     = IDLE;
          rd_idx_d    = '0;
          out_valid_d = 1'b0;
          out_idx_d   = '0;
          out_sum_d   = '0;
          out_cnt_d   = '0;
          out_last_d  = 1'b0;
        end else begin
`ifdef SAO_STAT_SKIP_EMPTY_EN
          if (out_valid_q) begin
            if (bus.out_ready) begin
              out_valid_d = 1'b0;
              rd_idx_d    = rd_idx_q + CATE_W'(1);
            end
          end else if (rd_cnt_c != '0) begin
            out_valid_d = 1'b1;
            out_idx_d   = rd_idx_q;
            out_sum_d   = rd_sum_c;
            out_cnt_d   = rd_cnt_c;
            out_last_d  = !any_later_c;
          end else if (rd_idx_q == CATE_W'(N_CATE - 1)) begin
            // Only reachable when every category is empty.
            out_valid_d = 1'b1;
            out_idx_d   = '0;
            out_sum_d   = '0;
            out_cnt_d   = '0;
            out_last_d  = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + CATE_W'(1);
          end
`else
          if (out_valid_q && bus.out_ready) begin
            rd_idx_d   = sel_idx_c;
            out_idx_d  = sel_idx_c;
            out_sum_d  = rd_sum_c;
            out_cnt_d  = rd_cnt_c;
            out_last_d = (sel_idx_c == CATE_W'(N_CATE - 1));
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != IDLE);

    // Synchronous clear aborts any CTB in flight.
    if (!rst_n) begin
      state_d     = IDLE;
      flush_d     = 1'b0;
      rd_idx_d    = '0;
      s1_valid_d  = 1'b0;
      s1_inc_d    = '0;
      for (int unsigned i = 0; i < N_PIX; i++) begin
        s1_cate_d[i] = '0;
        s1_diff_d[i] = '0;
      end
      for (int unsigned c = 0; c < N_CATE; c++) begin
        sum_d[c] = '0;
        cnt_d[c] = '0;
      end
      in_ready_d  = 1'b0;
      busy_d      = 1'b0;
      out_valid_d = 1'b0;
      out_idx_d   = '0;
      out_sum_d   = '0;
      out_cnt_d   = '0;
      out_last_d  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      flush_q     <= 1'b0;
      rd_idx_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_inc_q    <= '0;
      for (int unsigned i = 0; i < N_PIX; i++) begin
        s1_cate_q[i] <= '0;
        s1_diff_q[i] <= '0;
      end
      for (int unsigned c = 0; c < N_CATE; c++) begin
        sum_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      rd_idx_q    <= rd_idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_inc_q    <= s1_inc_d;
      s1_cate_q   <= s1_cate_d;
      s1_diff_q   <= s1_diff_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_sao_stat_cate_accum.sv
// Bench for sao_stat_cate_accum: EO-sized configuration (5 categories) with narrow
// accumulators so that sum and count saturation are reachable in a short run.
module tb_sao_stat_cate_accum;
  localparam int N_PIX  = 4;
  localparam int DIFF_W = 5;
  localparam int N_CATE = 5;
  localparam int CATE_W = 3;
  localparam int ACC_W  = 8;
  localparam int CNT_W  = 8;
  localparam int SMAX   = (1 << (ACC_W - 1)) - 1;
  localparam int SMIN   = -(1 << (ACC_W - 1));
  localparam int CMAX   = (1 << CNT_W) - 1;

`ifdef SAO_STAT_SKIP_EMPTY_EN
  localparam int T1_HS = 2, T1_LAST = 2, EMPTY_HS = 1, EMPTY_LAST = 0;
`else
  localparam int T1_HS = 5, T1_LAST = 4, EMPTY_HS = 5, EMPTY_LAST = 4;
`endif

  typedef struct { int idx; int sum; int cnt; bit last; } exp_t;

  logic clk, arst_n, rst_n, ctb_start, busy;
  sao_stat_cate_accum_if #(.N_PIX(N_PIX), .DIFF_W(DIFF_W), .CATE_W(CATE_W),
                           .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  sao_stat_cate_accum #(.N_PIX(N_PIX), .DIFF_W(DIFF_W), .N_CATE(N_CATE), .CATE_W(CATE_W),
                        .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .ctb_start(ctb_start), .busy(busy), .bus(bus)
  );

  int   n_vec = 0, n_err = 0, cyc = 0;
  int   m_sum [N_CATE];
  int   m_cnt [N_CATE];
  exp_t exp_q [$];
  exp_t ef;
  int   got_sum [N_CATE];
  int   got_cnt [N_CATE];
  int   hs_count, got_last_idx;
  int   t_last, t_first;
  bit   seen_first;
  bit   prev_stall = 0;
  int   p_idx, p_sum, p_cnt;
  bit   p_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Output checker: every valid cycle is compared with the head of the expected queue.
  always @(negedge clk) begin
    if (arst_n && rst_n) begin
      if (prev_stall) begin
        n_vec++;
        if (!bus.out_valid || int'(bus.out_idx) != p_idx || int'(bus.out_sum) != p_sum ||
            int'(bus.out_cnt) != p_cnt || bus.out_last != p_last) begin
          n_err++;
          $display("FAIL held_data: got v=%0b idx=%0d sum=%0d cnt=%0d, required v=1 idx=%0d sum=%0d cnt=%0d",
                   bus.out_valid, bus.out_idx, bus.out_sum, bus.out_cnt, p_idx, p_sum, p_cnt);
        end
      end
      prev_stall = 0;
      if (bus.out_valid) begin
        if (!seen_first) begin
          seen_first = 1;
          t_first = cyc;
        end
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_out: got idx=%0d sum=%0d cnt=%0d, required no output",
                   bus.out_idx, bus.out_sum, bus.out_cnt);
        end else begin
          ef = exp_q[0];
          if (int'(bus.out_idx) != ef.idx || int'(bus.out_sum) != ef.sum ||
              int'(bus.out_cnt) != ef.cnt || bus.out_last != ef.last) begin
            n_err++;
            $display("FAIL result: got (%0d,%0d,%0d,last=%0b), required (%0d,%0d,%0d,last=%0b)",
                     bus.out_idx, bus.out_sum, bus.out_cnt, bus.out_last,
                     ef.idx, ef.sum, ef.cnt, ef.last);
          end
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
            if (int'(bus.out_idx) < N_CATE) begin
              got_sum[bus.out_idx] = int'(bus.out_sum);
              got_cnt[bus.out_idx] = int'(bus.out_cnt);
            end
            if (bus.out_last) got_last_idx = int'(bus.out_idx);
          end else begin
            prev_stall = 1;
            p_idx  = int'(bus.out_idx);
            p_sum  = int'(bus.out_sum);
            p_cnt  = int'(bus.out_cnt);
            p_last = bus.out_last;
          end
        end
      end
    end else begin
      prev_stall = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  function automatic int clamp_s(input int v);
    int r;
    r = v;
    if (r > SMAX) r = SMAX;
    if (r < SMIN) r = SMIN;
    return r;
  endfunction

  // Starts a CTB; with_stray also presents a beat in the same cycle, which must be dropped.
  task automatic start_ctb(input bit with_stray);
    for (int c = 0; c < N_CATE; c++) begin
      m_sum[c] = 0;
      m_cnt[c] = 0;
      got_sum[c] = -999;
      got_cnt[c] = -999;
    end
    hs_count = 0;
    got_last_idx = -1;
    seen_first = 0;
    ctb_start = 1'b1;
    if (with_stray) begin
      bus.in_valid = 1'b1;
      bus.in_use   = '1;
      bus.in_last  = 1'b1;
      for (int p = 0; p < N_PIX; p++) begin
        bus.in_cate[p] = '0;
        bus.in_diff[p] = DIFF_W'(5);
      end
      chk("in_ready_idle", int'(bus.in_ready), 0);
    end
    tick();
    ctb_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    chk("in_ready_accum", int'(bus.in_ready), 1);
  endtask

  // Element k of cv/dv is pixel N_PIX-1-k (listing order is MSB pixel first).
  task automatic send_beat(input int cv[N_PIX], input int dv[N_PIX],
                           input logic [N_PIX-1:0] use_v, input logic last);
    int bs [N_CATE];
    int bc [N_CATE];
    int p, k, tb;
    bit acc;
    for (int c = 0; c < N_CATE; c++) begin
      bs[c] = 0;
      bc[c] = 0;
    end
    for (int j = 0; j < N_PIX; j++) begin
      p = N_PIX - 1 - j;
      bus.in_cate[p] = CATE_W'(cv[j]);
      bus.in_diff[p] = DIFF_W'(dv[j]);
      if (use_v[p] && cv[j] >= 0 && cv[j] < N_CATE) begin
        bs[cv[j]] += dv[j];
        bc[cv[j]] += 1;
      end
    end
    bus.in_use = use_v;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    k = 0;
    acc = 0;
    tb = 0;
    while (!acc && k < 20) begin
      acc = bus.in_ready;
      tb = cyc;
      tick();
      k++;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept: got in_ready=0 for 20 cycles, required acceptance");
    end else begin
      for (int c = 0; c < N_CATE; c++) begin
        m_sum[c] = clamp_s(m_sum[c] + bs[c]);
        m_cnt[c] = (m_cnt[c] + bc[c] > CMAX) ? CMAX : m_cnt[c] + bc[c];
      end
      if (last) t_last = tb;
    end
  endtask

  // Expected readout derived from the model at the end of the CTB.
  task automatic push_expect();
    exp_t e;
    for (int c = 0; c < N_CATE; c++) begin
`ifdef SAO_STAT_SKIP_EMPTY_EN
      if (m_cnt[c] == 0) continue;
`endif
      e.idx = c;
      e.sum = m_sum[c];
      e.cnt = m_cnt[c];
      e.last = 0;
      exp_q.push_back(e);
    end
    if (exp_q.size() == 0) begin
      e.idx = 0;
      e.sum = 0;
      e.cnt = 0;
      e.last = 1;
      exp_q.push_back(e);
    end else begin
      exp_q[exp_q.size()-1].last = 1;
    end
  endtask

  task automatic wait_done(input bit bp);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && !busy) && k < 300) begin
      tick();
      if (bp) bus.out_ready = !bus.out_ready;
      k++;
    end
    bus.out_ready = 1'b1;
    if (k >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL readout_timeout: got %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int k;
    arst_n = 1'b1;
    rst_n = 1'b1;
    ctb_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_use = '0;
    bus.in_cate = '0;
    bus.in_diff = '0;
    bus.out_ready = 1'b1;
    #2 arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    chk("rst_out_cnt", int'(bus.out_cnt), 0);
    chk("rst_out_last", int'(bus.out_last), 0);

    // Single EO beat with duplicate categories.
    start_ctb(0);
    send_beat('{1, 1, 2, 1}, '{3, -2, 4, 5}, 4'b1111, 1'b1);
    push_expect();
    wait_done(0);
    chk("t1_sum1", got_sum[1], 6);
    chk("t1_cnt1", got_cnt[1], 3);
    chk("t1_sum2", got_sum[2], 4);
    chk("t1_cnt2", got_cnt[2], 1);
    chk("t1_handshakes", hs_count, T1_HS);
    chk("t1_last_idx", got_last_idx, T1_LAST);
`ifndef SAO_STAT_SKIP_EMPTY_EN
    chk("t1_latency", t_first - t_last, 3);
    chk("t1_cnt0", got_cnt[0], 0);
`endif

    // Use masking, out-of-range category, stray beat with ctb_start, ctb_start in ACCUM.
    start_ctb(1);
    send_beat('{2, 2, 2, 2}, '{1, 1, 1, 1}, 4'b1111, 1'b0);
    ctb_start = 1'b1;
    tick();
    ctb_start = 1'b0;
    send_beat('{0, 0, 0, 7}, '{-8, 7, 1, 5}, 4'b0111, 1'b1);
    push_expect();
    wait_done(0);
    chk("t2_sum0", got_sum[0], 8);
    chk("t2_cnt0", got_cnt[0], 2);
    chk("t2_sum2", got_sum[2], 4);
    chk("t2_cnt2", got_cnt[2], 4);

    // Positive sum saturation.
    start_ctb(0);
    for (int i = 0; i < 40; i++)
      send_beat('{3, 3, 3, 3}, '{15, 15, 15, 15}, 4'b1111, 1'(i == 39));
    push_expect();
    wait_done(0);
    chk("t3_sum3_sat", got_sum[3], 127);
    chk("t3_cnt3", got_cnt[3], 160);

    // Negative sum and count saturation.
    start_ctb(0);
    for (int i = 0; i < 70; i++)
      send_beat('{0, 0, 0, 0}, '{-16, -16, -16, -16}, 4'b1111, 1'(i == 69));
    push_expect();
    wait_done(0);
    chk("t3b_sum0_sat", got_sum[0], -128);
    chk("t3b_cnt0_sat", got_cnt[0], 255);

    // Backpressure: out_ready toggles every cycle during readout.
    start_ctb(0);
    send_beat('{1, 1, 2, 1}, '{3, -2, 4, 5}, 4'b1111, 1'b1);
    push_expect();
    wait_done(1);
    chk("t4_handshakes", hs_count, T1_HS);
    chk("t4_sum1", got_sum[1], 6);

    // Abort during readout at idx 2, then a clean CTB.
    start_ctb(0);
    send_beat('{1, 1, 2, 1}, '{3, -2, 4, 5}, 4'b1111, 1'b1);
    push_expect();
    k = 0;
    while (!(bus.out_valid && int'(bus.out_idx) == 2) && k < 50) begin
      tick();
      k++;
    end
    chk("t5_reached_idx2", int'(k < 50), 1);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.delete();
    chk("t5_busy_after_clr", int'(busy), 0);
    chk("t5_valid_after_clr", int'(bus.out_valid), 0);
    chk("t5_ready_after_clr", int'(bus.in_ready), 0);
    start_ctb(0);
    send_beat('{4, 4, 4, 4}, '{1, 1, 1, 1}, 4'b1111, 1'b1);
    push_expect();
    wait_done(0);
    chk("t5_sum4", got_sum[4], 4);
    chk("t5_cnt4", got_cnt[4], 4);
    chk("t5_last_idx", got_last_idx, 4);
`ifndef SAO_STAT_SKIP_EMPTY_EN
    chk("t5_no_residue_sum1", got_sum[1], 0);
    chk("t5_no_residue_cnt2", got_cnt[2], 0);
`endif

    // All-unused CTB: the beat is accepted and honours in_last, contributing nothing.
    start_ctb(0);
    send_beat('{1, 2, 3, 4}, '{5, 5, 5, 5}, 4'b0000, 1'b1);
    push_expect();
    wait_done(0);
    chk("t6_handshakes", hs_count, EMPTY_HS);
    chk("t6_last_idx", got_last_idx, EMPTY_LAST);
    chk("t6_sum0", got_sum[0], 0);
    chk("t6_cnt0", got_cnt[0], 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sao_stat_cate_accum.md
Name: sao_stat_cate_accum

Overview:
- Parametrised successor of the SAO n-pixel statistics adder.
- Accepts N_PIX pixels per beat, each with a signed clipped diff, a category index and a use flag.
- Accumulates per-category diff sums and pixel counts over one CTB, then streams the N_CATE results to the offset-decision stage over a valid/ready handshake.
- Serves both EO (N_CATE=5) and BO (N_CATE=32) statistics.

Parameters:
- N_PIX, 4: pixels per input beat (1..8).
- DIFF_W, 5: signed diff width (diff_clip_bit+1).
- N_CATE, 32: number of categories.
- CATE_W, 5: category index width; must satisfy 2^CATE_W >= N_CATE.
- ACC_W, 18: signed sum accumulator width.
- CNT_W, 12: unsigned count width.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- rst_n  in  1  synchronous clear, active-low
- ctb_start  in  1  pulse: clear accumulators, enter ACCUM
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_last  in  1  marks final beat of CTB
- in_use  in  N_PIX  per-pixel include flag
- in_cate  in  N_PIX x CATE_W  per-pixel category
- in_diff  in  N_PIX x DIFF_W signed  per-pixel diff
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_idx  out  CATE_W  category index of result
- out_sum  out  ACC_W signed  accumulated diff sum
- out_cnt  out  CNT_W  accumulated pixel count
- out_last  out  1  final result of CTB
- busy  out  1  state != IDLE

Behaviour:
- Reset (arst_n low, or rst_n low at clk edge):
  - state=IDLE.
  - All outputs 0.
  - All accumulators 0.
  - Pipeline valids 0.
- States: IDLE, ACCUM, FLUSH, READ.
- IDLE:
  - in_ready=0.
  - ctb_start -> clear all sums/counts, go ACCUM next cycle.
- ACCUM:
  - in_ready=1.
  - Accepted beat enters S1: register inputs; diff forced to 0 and pixel excluded when in_use[i]=0 or in_cate[i]>=N_CATE.
  - S2 (one cycle later), for every category c:
    - sum[c] += sum of diffs with cate==c;
    - cnt[c] += number of included pixels with cate==c.
  - Per-category beat contribution is a combinational tree over N_PIX pixels. Width is DIFF_W+clog2(N_PIX), sign-extended.
  - Accepted beat with in_last=1 -> FLUSH.
- FLUSH:
  - in_ready=0.
  - Waits 2 cycles so the final beat has written S2, then READ with rd_idx=0.
- READ:
  - in_ready=0.
  - Outputs: out_valid=1, out_idx=rd_idx, out_sum=sum[rd_idx], out_cnt=cnt[rd_idx], out_last=(rd_idx==N_CATE-1).
  - Outputs hold stable while out_ready=0.
  - Handshake with out_last -> IDLE.
  - Otherwise handshake advances rd_idx.
- Latency: last beat accepted at cycle t -> first out_valid at t+3.
- Arithmetic:
  - sum saturates at +2^(ACC_W-1)-1 / -2^(ACC_W-1).
  - cnt saturates at 2^CNT_W-1; no wrap.
- Boundaries:
  - ctb_start outside IDLE is ignored.
  - ctb_start with in_valid in same cycle: the beat is not accepted (in_ready=0 in IDLE).
  - in_valid with all in_use=0 is accepted and counts as a beat (in_last honoured), contributing nothing.
  - rst_n low mid-ACCUM/READ aborts immediately to IDLE with cleared state; no partial output.
  - Duplicate categories within a beat all accumulate into the same entry in one cycle.

Optional Feature:
- Macro SAO_STAT_SKIP_EMPTY_EN.
- Defined:
  - READ skips categories with cnt==0; rd_idx advances one category per cycle until a non-empty one or the end.
  - out_last is asserted on the last non-empty category.
  - If all categories are empty, one beat is emitted: out_idx=0, out_sum=0, out_cnt=0, out_last=1.
- Undefined: all N_CATE categories are emitted in order.

Test Plan:
1. Single-beat EO case:
   - Setup: N_CATE=5, N_PIX=4, ctb_start; one beat cate={1,1,2,1}, diff={3,-2,4,5}, use=1111, last.
   - Expect: out (idx,sum,cnt) = (0,0,0),(1,6,3),(2,4,1),(3,0,0),(4,0,0); out_last on idx 4; first out_valid 3 cycles after the beat.
2. use masking and out-of-range category:
   - Stimulus: cate={0,0,0,7}, diff={-8,7,1,5}, use=0111, N_CATE=5.
   - Expect: idx0 sum=8, cnt=2; others 0.
3. Saturation:
   - Setup: ACC_W=8; 40 beats of all-pixel cate=3, diff=+15.
   - Expect: sum[3]=127 (saturated), cnt[3]=160.
4. Backpressure:
   - Stimulus: out_ready toggles 0/1 every cycle during READ.
   - Expect: each idx presented exactly once with stable data while stalled; exactly N_CATE handshakes.
5. Abort and restart:
   - Stimulus: rst_n low for one cycle mid-READ at idx 2, then a new CTB with one beat cate={4,4,4,4}, diff={1,1,1,1}.
   - Expect: busy=0 and out_valid=0 after the reset cycle; the new CTB reads idx4 sum=4, cnt=4 with no residue from the aborted CTB.
6. SAO_STAT_SKIP_EMPTY_EN defined:
   - Stimulus: the scenario 1 stimulus.
   - Expect: only idx1 and idx2 emitted; out_last on idx2.
   - Stimulus: an all-use=0 CTB.
   - Expect: a single (0,0,0) beat with out_last=1.
